// File: rtl/dsi_lanes_ctrl_if.sv
// Byte-stream and per-lane serializer bundle for dsi_lanes_ctrl.
// master = upstream assembler plus lane side, slave = the sequencer.
interface dsi_lanes_ctrl_if #(parameter int LANES = 4);
  logic               s_valid;
  logic [7:0]         s_data;
  logic               s_last;
  logic               s_hs;
  logic               s_ready;
  logic [8*LANES-1:0] lane_data;
  logic [LANES-1:0]   lane_write;
  logic               lane_type;
  logic [LANES-1:0]   lane_eof;
  logic [LANES-1:0]   lane_dummy;
  logic [LANES-1:0]   lane_request;
  logic [LANES-1:0]   lane_active;

  modport master (
    output s_valid, s_data, s_last, s_hs, lane_request, lane_active,
    input  s_ready, lane_data, lane_write, lane_type, lane_eof, lane_dummy
  );
  modport slave (
    input  s_valid, s_data, s_last, s_hs, lane_request, lane_active,
    output s_ready, lane_data, lane_write, lane_type, lane_eof, lane_dummy
  );
endinterface

// File: rtl/dsi_lanes_ctrl.sv
// DSI lane sequencer: stripes a byte burst round-robin over 1..LANES lanes,
// closes every lane's burst with eof/dummy and enforces an idle gap.
// Optional stat counters: define DSI_LANES_CTRL_STATS_EN.
module dsi_lanes_ctrl #(
  parameter int LANES      = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic             clk_base,
  input  logic             reset,
  input  logic [1:0]       lanes_cfg,
  dsi_lanes_ctrl_if.slave  bus,
  output logic             busy
`ifdef DSI_LANES_CTRL_STATS_EN
  ,
  output logic [15:0]      stat_bursts,
  output logic [31:0]      stat_bytes
`endif
);
  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE_PEND, ISSUE_LAST, DRAIN, GAP} state_t;

  state_t                 state, state_nx;
  logic [LANES-1:0][7:0]  stage, pend, stage_in;
  logic                   pend_valid;
  logic [2:0]             n, cnt, final_cnt;
  logic [2:0]             cfg_n, in_n, in_cnt;
  logic                   hs;
  logic [7:0]             gap_cnt;
  logic [LANES-1:0]       act_mask, fin_mask;
  logic                   all_req, in_word_end, accept, use_stage;
  logic [LANES-1:0]       wr, eof, dummy;
  logic [8*LANES-1:0]     lane_data;

  assign cfg_n = ({1'b0, lanes_cfg} >= 3'(LANES)) ? 3'(LANES) : {1'b0, lanes_cfg} + 3'd1;

  // In IDLE the first byte uses the live lane count before it is latched.
  assign in_n        = (state == IDLE) ? cfg_n : n;
  assign in_cnt      = (state == IDLE) ? 3'd0 : cnt;
  assign in_word_end = (in_cnt == in_n - 3'd1);

  for (genvar i = 0; i < LANES; i++) begin : g_mask
    assign act_mask[i] = (3'(i) < n);
    assign fin_mask[i] = (3'(i) < final_cnt);
  end

  assign all_req = &(bus.lane_request | ~act_mask);

  always_comb begin
    stage_in = stage;
    for (int i = 0; i < LANES; i++)
      if (3'(i) == in_cnt) stage_in[i] = bus.s_data;
  end

  always_comb begin
    state_nx    = state;
    bus.s_ready = 1'b0;
    accept      = 1'b0;
    use_stage   = 1'b0;
    wr          = '0;
    eof         = '0;
    dummy       = '0;
    case (state)
      IDLE, COLLECT: begin
        // Completing a word while one is still pending needs the lanes ready.
        bus.s_ready = !(in_word_end && pend_valid && !all_req);
        accept      = bus.s_valid && bus.s_ready;
        if (accept && in_word_end && !bus.s_last && pend_valid) wr = act_mask;
        if (accept) state_nx = bus.s_last ? ISSUE_PEND : COLLECT;
      end
      ISSUE_PEND: begin
        if (pend_valid) begin
          if (all_req) begin
            wr       = act_mask;
            eof      = act_mask & ~fin_mask;
            state_nx = ISSUE_LAST;
          end
        end else if (final_cnt != n) begin
          // Short burst: lanes with no byte get a dummy closing byte.
          if (all_req) begin
            wr       = act_mask & ~fin_mask;
            eof      = act_mask & ~fin_mask;
            dummy    = act_mask & ~fin_mask;
            state_nx = ISSUE_LAST;
          end
        end else begin
          state_nx = ISSUE_LAST;
        end
      end
      ISSUE_LAST: begin
        use_stage = 1'b1;
        if (all_req) begin
          wr       = fin_mask;
          eof      = fin_mask;
          state_nx = DRAIN;
        end
      end
      DRAIN: if ((bus.lane_active & act_mask) == '0) state_nx = GAP;
      GAP:   if (GAP_CYCLES == 0 || gap_cnt == 8'(GAP_CYCLES - 1)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    lane_data = '0;
    for (int i = 0; i < LANES; i++)
      if (wr[i] && !dummy[i]) lane_data[8*i +: 8] = use_stage ? stage[i] : pend[i];
  end

  assign bus.lane_data  = lane_data;
  assign bus.lane_write = wr;
  assign bus.lane_eof   = eof;
  assign bus.lane_dummy = dummy;
  assign bus.lane_type  = hs;
  assign busy           = (state != IDLE);

  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      stage      <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      n          <= 3'd0;
      cnt        <= 3'd0;
      final_cnt  <= 3'd0;
      hs         <= 1'b0;
      gap_cnt    <= 8'd0;
    end else begin
      state   <= state_nx;
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (accept) begin
        if (state == IDLE) begin
          n  <= cfg_n;
          hs <= bus.s_hs;
        end
        if (bus.s_last) begin
          stage     <= stage_in;
          final_cnt <= in_cnt + 3'd1;
          cnt       <= 3'd0;
        end else if (in_word_end) begin
          pend       <= stage_in;
          pend_valid <= 1'b1;
          cnt        <= 3'd0;
        end else begin
          stage <= stage_in;
          cnt   <= in_cnt + 3'd1;
        end
      end
      if (state == ISSUE_PEND && state_nx == ISSUE_LAST) pend_valid <= 1'b0;
      if (state == GAP && state_nx == IDLE) hs <= 1'b0;
    end
  end

`ifdef DSI_LANES_CTRL_STATS_EN
  always_ff @(posedge clk_base or posedge reset) begin
    if (reset) begin
      stat_bursts <= 16'd0;
      stat_bytes  <= 32'd0;
    end else begin
      if (accept) stat_bytes <= stat_bytes + 32'd1;
      if (state != DRAIN && state_nx == DRAIN) stat_bursts <= stat_bursts + 16'd1;
    end
  end
`endif
endmodule
